// File: rtl/sum_series_sched_if.sv
// Bundle between the scheduler, its requesters and the shared sum_series datapath.
// The scheduler takes the slave view; the requester/datapath side takes the master view.
interface sum_series_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   Req;
    logic [NREQ*W-1:0] NIn;
    logic [NREQ-1:0]   Ack;
    logic [NREQ-1:0]   Done;
    logic              Err;
    logic [W-1:0]      Result;
    logic              Busy;
    logic [W-1:0]      Data_in;
    logic              LoadN;
    logic              Clear;
    logic              LoadR;
    logic              IncC;
    logic              CltN;
    logic [W-1:0]      Rw;

    modport slave (
        input  Req, NIn, CltN, Rw,
        output Ack, Done, Err, Result, Busy, Data_in, LoadN, Clear, LoadR, IncC
    );

    modport master (
        output Req, NIn, CltN, Rw,
        input  Ack, Done, Err, Result, Busy, Data_in, LoadN, Clear, LoadR, IncC
    );
endinterface

// File: rtl/sum_series_sched.sv
// Round-robin scheduler sharing one sum_series datapath among NREQ requesters.
// Drives the datapath strobes from CltN and returns the captured sum with a done pulse.
module sum_series_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    sum_series_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0] SC_MAX = '1;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, STEP, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [W-1:0]    sc;
    logic [W-1:0]    sum_hold;
    logic            abort;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan from ptr upward, wrapping, and take the first pending request.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && bus.Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            sc       <= '0;
            sum_hold <= '0;
            abort    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    ptr   <= wrap_inc(idx);
                    sc    <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (bus.CltN && sc != SC_MAX) begin
                        state <= STEP;
                    end else begin
                        // CltN still high here means the step budget ran out.
                        abort    <= bus.CltN;
                        sum_hold <= bus.Rw;
                        state    <= DONE;
                    end
                end
                STEP: begin
                    sc    <= sc + 1'b1;
                    state <= CHECK;
                end
                DONE: begin
                    abort <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.LoadN   = (state == LOAD);
        bus.Clear   = (state == LOAD);
        bus.LoadR   = (state == STEP);
        bus.IncC    = (state == STEP);
        bus.Busy    = (state != IDLE);
        bus.Err     = (state == DONE) && abort;
        bus.Ack     = (state == LOAD) ? onehot(idx) : '0;
        bus.Done    = (state == DONE) ? onehot(idx) : '0;
        bus.Data_in = (state == LOAD) ? bus.NIn[idx*W +: W] : '0;
        bus.Result  = sum_hold;
    end
endmodule

// File: tb/tb_sum_series_sched.sv
// Directed bench for sum_series_sched with a behavioural sum_series datapath model.
module tb_sum_series_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    sum_series_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    sum_series_sched #(.NREQ(NREQ), .W(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    // Datapath model: counter starts at 1 on Clear, CltN = (C <= N), R accumulates C.
    logic [W-1:0] dp_n = '0;
    logic [W-1:0] dp_r = '0;
    logic [W-1:0] dp_c = '0;
    logic         force_clt = 1'b0;

    always @(posedge Clk) begin
        if (bus.LoadN) dp_n <= bus.Data_in;
        if (bus.Clear) begin
            dp_r <= '0;
            dp_c <= W'(1);
        end
        if (bus.LoadR) dp_r <= dp_r + dp_c;
        if (bus.IncC)  dp_c <= dp_c + W'(1);
    end

    assign bus.CltN = force_clt | (dp_c <= dp_n);
    assign bus.Rw   = dp_r;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int step_cnt = 0;
    int bad_oh  = 0;
    int ack_idx_q[$];
    int ack_t_q[$];
    int done_idx_q[$];
    int done_t_q[$];
    int done_err_q[$];
    int done_res_q[$];

    function automatic int first_bit(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event recorder, sampled shortly after each rising edge.
    always begin
        @(posedge Clk);
        #2;
        cyc++;
        if (bus.Ack != '0) begin
            if (!$onehot(bus.Ack)) bad_oh++;
            ack_idx_q.push_back(first_bit(bus.Ack));
            ack_t_q.push_back(cyc);
        end
        if (bus.Done != '0) begin
            if (!$onehot(bus.Done)) bad_oh++;
            done_idx_q.push_back(first_bit(bus.Done));
            done_t_q.push_back(cyc);
            done_err_q.push_back(int'(bus.Err));
            done_res_q.push_back(int'(bus.Result));
        end
        if (bus.LoadR || bus.IncC) step_cnt++;
    end

    task automatic clear_log();
        ack_idx_q.delete();
        ack_t_q.delete();
        done_idx_q.delete();
        done_t_q.delete();
        done_err_q.delete();
        done_res_q.delete();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int i = 0;
        while (ack_idx_q.size() < n && i < budget) begin
            @(negedge Clk);
            i++;
        end
        check("ack_wait", ack_idx_q.size(), n);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int i = 0;
        while (done_idx_q.size() < n && i < budget) begin
            @(negedge Clk);
            i++;
        end
        check("done_wait", done_idx_q.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, bus.Busy, 0);
        check({tag, "_pulses"}, {bus.Ack, bus.Done, bus.Err, bus.LoadN, bus.Clear, bus.LoadR, bus.IncC}, 0);
        check({tag, "_result"}, bus.Result, 0);
        check({tag, "_data_in"}, bus.Data_in, 0);
    endtask

    task automatic run_single(input int r, input int nval, input int exp_res,
                              input int exp_lat, input int exp_err, input string tag);
        int na, nd, req_t;
        na = ack_idx_q.size();
        nd = done_idx_q.size();
        @(negedge Clk);
        bus.NIn[r*W +: W] = W'(nval);
        bus.Req[r] = 1'b1;
        req_t = cyc;
        wait_acks(na + 1, 20);
        bus.Req[r] = 1'b0;
        wait_dones(nd + 1, 600);
        if (ack_idx_q.size() > na && done_idx_q.size() > nd) begin
            check({tag, "_grant_lat"}, ack_t_q[na] - req_t, 1);
            check({tag, "_ack_idx"}, ack_idx_q[na], r);
            check({tag, "_done_idx"}, done_idx_q[nd], r);
            check({tag, "_latency"}, done_t_q[nd] - ack_t_q[na], exp_lat);
            check({tag, "_result"}, done_res_q[nd], exp_res);
            check({tag, "_err"}, done_err_q[nd], exp_err);
        end
    endtask

    initial begin
        int exp4[4];
        int nd;
        exp4 = '{15, 21, 28, 36};
        bus.Req = '0;
        bus.NIn = '0;

        // Reset state
        repeat (3) @(negedge Clk);
        check_idle_outputs("rst");
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Single request, N=4
        run_single(0, 4, 10, 10, 0, "single");
        repeat (3) @(negedge Clk);
        check("single_ack_count", ack_idx_q.size(), 1);
        check("single_busy_after", bus.Busy, 0);

        // Table sweep on requester 2
        run_single(2, 9, 45, 20, 0, "n9");
        run_single(2, 12, 78, 26, 0, "n12");
        run_single(2, 3, 6, 8, 0, "n3");

        // All four requesting at reset release
        clear_log();
        @(negedge Clk);
        Rst = 1'b1;
        bus.Req = '1;
        bus.NIn = {8'd8, 8'd7, 8'd6, 8'd5};
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_acks(k + 1, 40);
            if (ack_idx_q.size() > k && ack_idx_q[k] >= 0) bus.Req[ack_idx_q[k]] = 1'b0;
        end
        bus.Req = '0;
        wait_dones(4, 200);
        if (done_idx_q.size() == 4 && ack_idx_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("all4_ack_idx%0d", k), ack_idx_q[k], k);
                check($sformatf("all4_done_idx%0d", k), done_idx_q[k], k);
                check($sformatf("all4_result%0d", k), done_res_q[k], exp4[k]);
                check($sformatf("all4_latency%0d", k), done_t_q[k] - ack_t_q[k], 2 * (5 + k) + 2);
                if (k > 0) check($sformatf("all4_gap%0d", k), ack_t_q[k] - done_t_q[k-1], 2);
            end
        end
        @(negedge Clk);
        check("all4_busy_end", bus.Busy, 0);

        // Fairness: 1 holds, 3 arrives mid-job
        clear_log();
        @(negedge Clk);
        bus.NIn[1*W +: W] = 8'd2;
        bus.Req[1] = 1'b1;
        wait_acks(1, 20);
        @(negedge Clk);
        bus.NIn[3*W +: W] = 8'd1;
        bus.Req[3] = 1'b1;
        wait_acks(2, 40);
        bus.Req[3] = 1'b0;
        wait_acks(3, 40);
        bus.Req[1] = 1'b0;
        wait_dones(3, 100);
        if (ack_idx_q.size() == 3 && done_res_q.size() == 3) begin
            check("fair_grant0", ack_idx_q[0], 1);
            check("fair_grant1", ack_idx_q[1], 3);
            check("fair_grant2", ack_idx_q[2], 1);
            check("fair_res0", done_res_q[0], 3);
            check("fair_res1", done_res_q[1], 1);
            check("fair_res2", done_res_q[2], 3);
        end

        // N=0: no step strobes
        repeat (2) @(negedge Clk);
        step_cnt = 0;
        run_single(0, 0, 0, 2, 0, "n0");
        check("n0_steps", step_cnt, 0);

        // Watchdog abort with CltN stuck high
        force_clt = 1'b1;
        run_single(1, 1, 128, 512, 1, "wdog");
        force_clt = 1'b0;
        repeat (2) @(negedge Clk);

        // Reset during STEP
        nd = done_idx_q.size();
        @(negedge Clk);
        bus.NIn[2*W +: W] = 8'd5;
        bus.Req[2] = 1'b1;
        wait_acks(ack_idx_q.size() + 1, 20);
        bus.Req[2] = 1'b0;
        for (int i = 0; i < 20 && !bus.LoadR; i++) @(negedge Clk);
        check("midrst_in_step", bus.LoadR, 1);
        Rst = 1'b1;
        @(negedge Clk);
        check_idle_outputs("midrst");
        Rst = 1'b0;
        repeat (30) @(negedge Clk);
        check("midrst_no_done", done_idx_q.size(), nd);

        check("onehot_viol", bad_oh, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
